matmul_result_drain: RTL and testbench

- Downstream stage of the matrix_multiplication top. Consumes the result (C) BRAM read port once the matmul finishes.
- On a rising edge of done_mat_mul it drives enable_reading_from_mem and a sequence of row addresses on addr_pi, then captures the returning data_from_out_mat rows.
- Presents the captured rows as a valid/ready stream with last-beat marking.
- A credit-limited skid FIFO absorbs the fixed read-path latency so that no row is lost under backpressure.

---
 rtl/matmul_result_drain.sv | 197 +++++++++++++++++++
 tb/tb_matmul_result_drain.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_result_drain.sv
// Drains matmul result rows from the C read port into a valid/ready stream with last-beat marking.
// Define DRAIN_ROW_TAG_EN to add out_row_idx, the C row address carried alongside each beat.
module matmul_result_drain #(
  parameter int DWIDTH          = 16,
  parameter int BB_MAT_MUL_SIZE = 8,
  parameter int AWIDTH          = 7,
  parameter int NUM_ROWS        = 8,
  parameter int BASE_ADDR       = 0,
  parameter int READ_LATENCY    = 6,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              done_mat_mul,
  output logic                              enable_reading_from_mem,
  output logic [AWIDTH-1:0]                 addr_pi,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] data_from_out_mat,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              drain_done
`ifdef DRAIN_ROW_TAG_EN
  ,
  output logic [AWIDTH-1:0]                 out_row_idx
`endif
);

  localparam int ROW_W = BB_MAT_MUL_SIZE * DWIDTH;
  localparam int CNT_W = $clog2(NUM_ROWS + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
`ifdef DRAIN_ROW_TAG_EN
  localparam int META_W = AWIDTH + 1;
`else
  localparam int META_W = 1;
`endif
  localparam int ENT_W = ROW_W + META_W;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

  state_t state, state_next;
  logic done_prev;
  logic start;
  logic issue;
  logic last_issue;
  logic [CNT_W-1:0] issued_cnt;
  logic [AWIDTH-1:0] addr_next;
  logic [AWIDTH-1:0] addr_q;
  logic [META_W-1:0] issue_meta;
  logic [OCC_W-1:0] outstanding;

  logic pipe_vld [READ_LATENCY];
  logic [META_W-1:0] pipe_meta [READ_LATENCY];
  logic pipe_busy;

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [OCC_W-1:0] fifo_cnt;
  logic [ENT_W-1:0] head;
  logic push, pop;
  logic head_last;

  assign start      = done_mat_mul & ~done_prev & (state == IDLE);
  assign issue      = (state == ISSUE) && (outstanding < OCC_W'(FIFO_DEPTH));
  assign last_issue = issue && (issued_cnt == CNT_W'(NUM_ROWS - 1));
  assign addr_next  = AWIDTH'(BASE_ADDR) + AWIDTH'(issued_cnt);

`ifdef DRAIN_ROW_TAG_EN
  assign issue_meta = {addr_next, last_issue};
`else
  assign issue_meta = last_issue;
`endif

  assign push      = pipe_vld[READ_LATENCY-1];
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid & out_ready;
  assign head      = fifo_mem[rd_ptr];
  assign head_last = head[ROW_W];

  // Outputs read as zero while the FIFO is empty so reset leaves the stream fully quiet.
  assign out_data = out_valid ? head[ROW_W-1:0] : '0;
  assign out_last = out_valid & head_last;
`ifdef DRAIN_ROW_TAG_EN
  assign out_row_idx = out_valid ? head[ROW_W+1 +: AWIDTH] : '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      done_prev <= 1'b0;
    end else begin
      state     <= state_next;
      done_prev <= done_mat_mul;
    end
  end

  // The last beat is always the final FIFO entry, so its handshake means the drain is complete.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (last_issue) state_next = FLUSH;
      FLUSH:   if (pop && head_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy                    = (state == ISSUE) || (state == FLUSH);
    drain_done              = (state == DONE);
    enable_reading_from_mem = (state == ISSUE) || ((state == FLUSH) && pipe_busy);
    addr_pi                 = issue ? addr_next : addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_cnt <= '0;
      addr_q     <= '0;
    end else begin
      if (state == IDLE) begin
        issued_cnt <= '0;
      end else if (issue) begin
        issued_cnt <= issued_cnt + 1'b1;
        addr_q     <= addr_next;
      end
    end
  end

  // Credits cover both rows still in the read pipe and rows waiting in the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_meta[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= issue;
      pipe_meta[0] <= issue_meta;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_meta[i] <= pipe_meta[i-1];
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      pipe_busy = pipe_busy | pipe_vld[i];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pipe_meta[READ_LATENCY-1], data_from_out_mat};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (fifo_cnt == OCC_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_matmul_result_drain.sv
// Scoreboard bench for matmul_result_drain: a C-memory model, random backpressure and a beat-order reference.
module tb_matmul_result_drain;

  localparam int DW   = 16;
  localparam int BB   = 8;
  localparam int AW   = 7;
  localparam int NR   = 12;
  localparam int BASE = 122;
  localparam int L    = 6;
  localparam int FD   = 8;
  localparam int RW   = BB * DW;

  typedef struct {
    logic [RW-1:0] data;
    logic          last;
    logic [AW-1:0] tag;
  } beat_t;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
  } mem_req_t;

  logic clk;
  logic reset;
  logic done_mat_mul;
  logic enable_reading_from_mem;
  logic [AW-1:0] addr_pi;
  logic [RW-1:0] data_from_out_mat;
  logic [RW-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic busy;
  logic drain_done;
`ifdef DRAIN_ROW_TAG_EN
  logic [AW-1:0] out_row_idx;
`endif

  int tests = 0;
  int fails = 0;
  int dd_count = 0;
  int beat_count = 0;
  int ready_mode = 0;
  beat_t exp_q[$];
  mem_req_t hist[$];

  matmul_result_drain #(
    .DWIDTH(DW), .BB_MAT_MUL_SIZE(BB), .AWIDTH(AW), .NUM_ROWS(NR),
    .BASE_ADDR(BASE), .READ_LATENCY(L), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .done_mat_mul(done_mat_mul),
    .enable_reading_from_mem(enable_reading_from_mem),
    .addr_pi(addr_pi),
    .data_from_out_mat(data_from_out_mat),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .drain_done(drain_done)
`ifdef DRAIN_ROW_TAG_EN
    ,
    .out_row_idx(out_row_idx)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [RW-1:0] rowValue(input logic [AW-1:0] a);
    logic [RW-1:0] v;
    for (int k = 0; k < BB; k++) v[k*DW +: DW] = 16'(int'(a) * 100 + k + 1);
    return v;
  endfunction

  function automatic logic [AW-1:0] rowAddr(input int i);
    return AW'((BASE + i) % (1 << AW));
  endfunction

  task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic done_lvl);
    done_mat_mul = done_lvl;
  endtask

  // Reference: a drain yields rows BASE..BASE+NR-1 (mod 2^AW) in order, last flag on the final one.
  task automatic pushDrain();
    beat_t b;
    for (int i = 0; i < NR; i++) begin
      b.tag  = rowAddr(i);
      b.data = rowValue(b.tag);
      b.last = (i == NR - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic waitDrains(input int target);
    for (int i = 0; i < 3000 && dd_count < target; i++) @(negedge clk);
    checkOutput("drain_done_count", RW'(dd_count), RW'(target));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_enable"}, RW'(enable_reading_from_mem), '0);
    checkOutput({tag, "_addr"}, RW'(addr_pi), '0);
    checkOutput({tag, "_valid"}, RW'(out_valid), '0);
    checkOutput({tag, "_last"}, RW'(out_last), '0);
    checkOutput({tag, "_data"}, out_data, '0);
    checkOutput({tag, "_busy"}, RW'(busy), '0);
    checkOutput({tag, "_drain_done"}, RW'(drain_done), '0);
`ifdef DRAIN_ROW_TAG_EN
    checkOutput({tag, "_row_idx"}, RW'(out_row_idx), '0);
`endif
  endtask

  // C memory: data for an address appears L cycles after it was presented with enable high.
  initial begin
    data_from_out_mat = '0;
    forever begin
      @(negedge clk);
      hist.push_front('{enable_reading_from_mem, addr_pi});
      if (hist.size() > L + 1) void'(hist.pop_back());
      if (hist.size() == L + 1 && hist[L].en) data_from_out_mat = rowValue(hist[L].addr);
      else data_from_out_mat = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 99) >= 30);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold stability under backpressure.
  initial begin
    logic prev_stall;
    logic [RW-1:0] prev_data;
    logic prev_last;
    beat_t e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        checkOutput("hold_valid", RW'(out_valid), RW'(1));
        checkOutput("hold_data", out_data, prev_data);
        checkOutput("hold_last", RW'(out_last), RW'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", out_data, '0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_data", out_data, e.data);
          checkOutput("beat_last", RW'(out_last), RW'(e.last));
`ifdef DRAIN_ROW_TAG_EN
          checkOutput("beat_row_idx", RW'(out_row_idx), RW'(e.tag));
`endif
        end
        beat_count++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (drain_done) begin
        dd_count++;
        checkOutput("done_queue_empty", RW'(exp_q.size()), '0);
        checkOutput("done_busy", RW'(busy), '0);
      end
    end
  end

  initial begin
    int dd_before;
    int b0;
    reset = 1'b1;
    applyStimulus(1'b0);
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Full-throughput drain with exact issue and first-beat timing.
    ready_mode = 1;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1);
    pushDrain();
    for (int k = 0; k < NR; k++) begin
      @(negedge clk);
      checkOutput("issue_addr", RW'(addr_pi), RW'(rowAddr(k)));
      checkOutput("issue_enable", RW'(enable_reading_from_mem), RW'(1));
      checkOutput("issue_busy", RW'(busy), RW'(1));
      checkOutput("first_beat_timing", RW'(out_valid), RW'(k >= L + 1));
    end
    applyStimulus(1'b0);
    waitDrains(1);
    @(negedge clk);
    checkOutput("idle_busy", RW'(busy), '0);
    checkOutput("idle_enable", RW'(enable_reading_from_mem), '0);

    // Full backpressure: credits stop issue at FIFO_DEPTH rows.
    ready_mode = 0;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1);
    pushDrain();
    repeat (30) @(negedge clk);
    checkOutput("stall_addr", RW'(addr_pi), RW'(rowAddr(FD - 1)));
    checkOutput("stall_enable", RW'(enable_reading_from_mem), RW'(1));
    checkOutput("stall_valid", RW'(out_valid), RW'(1));
    checkOutput("stall_data", out_data, rowValue(rowAddr(0)));
    applyStimulus(1'b0);
    ready_mode = 1;
    waitDrains(2);

    // Random backpressure, held level and a second edge mid-drain.
    ready_mode = 2;
    @(negedge clk);
    applyStimulus(1'b1);
    pushDrain();
    repeat (8) @(negedge clk);
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    checkOutput("mid_drain_busy", RW'(busy), RW'(1));
    applyStimulus(1'b1);
    repeat (100) @(negedge clk);
    waitDrains(3);
    checkOutput("held_level_single_drain", RW'(dd_count), RW'(3));
    checkOutput("held_level_busy", RW'(busy), '0);
    applyStimulus(1'b0);
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      applyStimulus(1'b1);
      pushDrain();
      @(negedge clk);
      applyStimulus(1'b0);
      waitDrains(4 + n);
    end

    // Reset after the third beat, then restart with done_mat_mul still high.
    ready_mode = 1;
    repeat (2) @(negedge clk);
    dd_before = dd_count;
    b0 = beat_count;
    applyStimulus(1'b1);
    pushDrain();
    for (int i = 0; i < 200 && beat_count < b0 + 3; i++) @(negedge clk);
    checkOutput("reach_third_beat", RW'(beat_count >= b0 + 3), RW'(1));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pushDrain();
    @(negedge clk);
    checkOutput("restart_addr", RW'(addr_pi), RW'(rowAddr(0)));
    checkOutput("restart_busy", RW'(busy), RW'(1));
    waitDrains(dd_before + 1);
    applyStimulus(1'b0);
    repeat (20) @(negedge clk);
    checkOutput("no_extra_drain_done", RW'(dd_count), RW'(dd_before + 1));
    checkOutput("final_queue_empty", RW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
